// File: rtl/pam4_rx_demapper.sv
// pam4_rx_demapper
//   Receive-side Gray PAM4 demapper. Slices a signed channel sample into one
//   of four levels using three thresholds, maps the level back to its 2-bit
//   Gray symbol, buffers symbols in a small FIFO and serializes them MSB
//   first onto a ready/valid bit stream.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   sample_in         signed channel sample (SAMPLE_W bits)
//   sample_in_valid   sample qualifier, no backpressure
//   bit_out           serialized data bit (registered)
//   bit_out_valid     bit_out qualifier (registered)
//   bit_out_ready     downstream accepts bit_out
//   fifo_level        symbols currently buffered (hold register excluded)
//   overflow          sticky: a symbol was dropped on a full FIFO
//   hist_clr          clears the level histogram       (PAM4_RX_LEVEL_HIST_EN)
//   hist_cnt0..3      saturating per-level counters    (PAM4_RX_LEVEL_HIST_EN)
//
// Optional feature macro: PAM4_RX_LEVEL_HIST_EN (level histogram counters).
module pam4_rx_demapper #(
  parameter int SAMPLE_W = 8,
  parameter int TH_LO    = -64,
  parameter int TH_MID   = 0,
  parameter int TH_HI    = 64,
  parameter int DEPTH    = 4
`ifdef PAM4_RX_LEVEL_HIST_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_in_valid,
  output logic                       bit_out,
  output logic                       bit_out_valid,
  input  logic                       bit_out_ready,
`ifdef PAM4_RX_LEVEL_HIST_EN
  input  logic                       hist_clr,
  output logic [CNT_W-1:0]           hist_cnt0,
  output logic [CNT_W-1:0]           hist_cnt1,
  output logic [CNT_W-1:0]           hist_cnt2,
  output logic [CNT_W-1:0]           hist_cnt3,
`endif
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [SAMPLE_W-1:0] TH_LO_S  = SAMPLE_W'(TH_LO);
  localparam logic signed [SAMPLE_W-1:0] TH_MID_S = SAMPLE_W'(TH_MID);
  localparam logic signed [SAMPLE_W-1:0] TH_HI_S  = SAMPLE_W'(TH_HI);

  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO} state_e;

  // Slicer: a sample equal to a threshold lands on the upper level.
  logic [1:0] lvl, sym;
  always_comb begin
    lvl = 2'd0;
    if (sample_in >= TH_HI_S)       lvl = 2'd3;
    else if (sample_in >= TH_MID_S) lvl = 2'd2;
    else if (sample_in >= TH_LO_S)  lvl = 2'd1;
    case (lvl)
      2'd0:    sym = 2'b00;
      2'd1:    sym = 2'b01;
      2'd2:    sym = 2'b11;
      default: sym = 2'b10;
    endcase
  end

  // Symbol FIFO
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push;
  state_e        state_q;
  logic          lsb_q, bit_out_q, vld_q;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  // Pop from IDLE, or back-to-back when the LSB of the current symbol is taken.
  assign pop   = !empty && ((state_q == IDLE) || (state_q == BIT_LO && bit_out_ready));
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push  = sample_in_valid && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = ovf_q | (sample_in_valid & !push);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sym;
  end

  // Serializer: MSB goes straight to bit_out on pop, only the LSB is held.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      lsb_q     <= 1'b0;
      bit_out_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          lsb_q     <= mem_q[rd_ptr_q][0];
          bit_out_q <= mem_q[rd_ptr_q][1];
          vld_q     <= 1'b1;
          state_q   <= BIT_HI;
        end
        BIT_HI: if (bit_out_ready) begin
          bit_out_q <= lsb_q;
          state_q   <= BIT_LO;
        end
        BIT_LO: if (bit_out_ready) begin
          if (pop) begin
            lsb_q     <= mem_q[rd_ptr_q][0];
            bit_out_q <= mem_q[rd_ptr_q][1];
            state_q   <= BIT_HI;
          end else begin
            bit_out_q <= 1'b0;
            vld_q     <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          bit_out_q <= 1'b0;
          vld_q     <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bit_out       = bit_out_q;
  assign bit_out_valid = vld_q;
  assign fifo_level    = cnt_q;
  assign overflow      = ovf_q;

`ifdef PAM4_RX_LEVEL_HIST_EN
  // Counts every valid sample, including those dropped on overflow.
  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W-1:0] hist_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hist_d[i] = hist_q[i];
      if (hist_clr)
        hist_d[i] = '0;
      else if (sample_in_valid && lvl == 2'(i) && hist_q[i] != '1)
        hist_d[i] = hist_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rstn) hist_q[i] <= '0;
      else       hist_q[i] <= hist_d[i];
    end
  end

  assign hist_cnt0 = hist_q[0];
  assign hist_cnt1 = hist_q[1];
  assign hist_cnt2 = hist_q[2];
  assign hist_cnt3 = hist_q[3];
`endif

endmodule

// File: tb/tb_pam4_rx_demapper.sv
// Bench for pam4_rx_demapper: directed cases with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_pam4_rx_demapper;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic signed [7:0] sample_in;
  logic              sample_in_valid;
  logic              bit_out, bit_out_valid, bit_out_ready;
  logic [2:0]        fifo_level;
  logic              overflow;
`ifdef PAM4_RX_LEVEL_HIST_EN
  logic              hist_clr;
  logic [CNT_W-1:0]  hist_cnt0, hist_cnt1, hist_cnt2, hist_cnt3;
`endif

  pam4_rx_demapper #(
    .SAMPLE_W(8), .TH_LO(-64), .TH_MID(0), .TH_HI(64), .DEPTH(DEPTH)
`ifdef PAM4_RX_LEVEL_HIST_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rstn(rstn),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .bit_out(bit_out), .bit_out_valid(bit_out_valid), .bit_out_ready(bit_out_ready),
`ifdef PAM4_RX_LEVEL_HIST_EN
    .hist_clr(hist_clr),
    .hist_cnt0(hist_cnt0), .hist_cnt1(hist_cnt1), .hist_cnt2(hist_cnt2), .hist_cnt3(hist_cnt3),
`endif
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Level from thresholds, then Gray symbol.
  function automatic int level_of(int s);
    if (s >= 64) return 3;
    if (s >= 0)  return 2;
    if (s >= -64) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] sym_of(int s);
    case (level_of(s))
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Model: a queue of buffered symbols plus the symbol on the wire and which
  // half of it is being shown.
  logic [1:0] mq[$];
  logic [1:0] m_cur;
  bit         m_busy, m_lo, m_ovf;
  int         m_hist[4];

  always @(posedge clk) begin
    bit popped;
    popped = 0;
    if (!rstn) begin
      mq.delete(); m_busy = 0; m_lo = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
    end else begin
      if (!m_busy) begin
        if (mq.size() > 0) begin m_cur = mq.pop_front(); m_busy = 1; m_lo = 0; popped = 1; end
      end else if (bit_out_ready) begin
        if (!m_lo) m_lo = 1;
        else if (mq.size() > 0) begin m_cur = mq.pop_front(); m_lo = 0; popped = 1; end
        else m_busy = 0;
      end
      if (sample_in_valid) begin
        if (mq.size() < DEPTH) mq.push_back(sym_of(int'(sample_in)));
        else m_ovf = 1;
      end
`ifdef PAM4_RX_LEVEL_HIST_EN
      for (int i = 0; i < 4; i++) begin
        if (hist_clr) m_hist[i] = 0;
        else if (sample_in_valid && level_of(int'(sample_in)) == i && m_hist[i] < (1 << CNT_W) - 1)
          m_hist[i]++;
      end
`endif
    end
    #1;
    chk("m_valid", 32'(bit_out_valid), 32'(m_busy));
    if (m_busy) chk("m_bit", 32'(bit_out), 32'(m_lo ? m_cur[0] : m_cur[1]));
    chk("m_level", 32'(fifo_level), 32'(mq.size()));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
`ifdef PAM4_RX_LEVEL_HIST_EN
    chk("m_hist0", 32'(hist_cnt0), 32'(m_hist[0]));
    chk("m_hist1", 32'(hist_cnt1), 32'(m_hist[1]));
    chk("m_hist2", 32'(hist_cnt2), 32'(m_hist[2]));
    chk("m_hist3", 32'(hist_cnt3), 32'(m_hist[3]));
`endif
  end

  // Accepted-bit collector and hold-stability check.
  logic rx[$];
  logic p_v = 0, p_r = 0, p_b = 0, p_rst = 1;
  always @(posedge clk) begin
    if (!p_rst && rstn && p_v && !p_r)
      chk("hold_stable", {30'd0, bit_out_valid, bit_out}, {30'd0, 1'b1, p_b});
    if (!rstn) rx.delete();
    else if (bit_out_valid && bit_out_ready) rx.push_back(bit_out);
    p_v = bit_out_valid; p_r = bit_out_ready; p_b = bit_out; p_rst = !rstn;
  end

  task automatic chk_rx(string nm, int n, logic [15:0] bits);
    chk({nm, "_count"}, 32'(rx.size()), 32'(n));
    for (int i = 0; i < n && i < rx.size(); i++)
      chk({nm, "_bit"}, 32'(rx[i]), 32'(bits[n-1-i]));
  endtask

  initial begin
    int t2v[4];
    int t3v[6];
    int t3l[6];
    int maxlvl;
    t2v = '{-64, -1, 0, 64};
    t3v = '{100, -100, 10, -10, 100, -100};
    t3l = '{1, 1, 2, 3, 4, 4};
    rstn = 0; sample_in = 0; sample_in_valid = 0; bit_out_ready = 1;
`ifdef PAM4_RX_LEVEL_HIST_EN
    hist_clr = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bit_out_valid), 0);
    chk("rst_bit", 32'(bit_out), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rstn = 1;

    // Single sample, latency and 2-cycle valid window.
    @(negedge clk); sample_in = -100; sample_in_valid = 1;
    @(negedge clk); sample_in_valid = 0;
    chk("t1_lvl_k", 32'(fifo_level), 1); chk("t1_vld_k", 32'(bit_out_valid), 0);
    @(negedge clk);
    chk("t1_vld_k1", 32'(bit_out_valid), 1); chk("t1_msb", 32'(bit_out), 0);
    chk("t1_lvl_k1", 32'(fifo_level), 0);
    @(negedge clk);
    chk("t1_vld_k2", 32'(bit_out_valid), 1); chk("t1_lsb", 32'(bit_out), 0);
    @(negedge clk);
    chk("t1_vld_k3", 32'(bit_out_valid), 0);

    // Threshold samples every 2 cycles.
    repeat (2) @(negedge clk);
    rx.delete(); maxlvl = 0;
    for (int i = 0; i < 4; i++) begin
      sample_in = 8'(t2v[i]); sample_in_valid = 1;
      @(negedge clk); sample_in_valid = 0;
      if (fifo_level > maxlvl) maxlvl = fifo_level;
      @(negedge clk);
      if (fifo_level > maxlvl) maxlvl = fifo_level;
    end
    repeat (4) @(negedge clk);
    chk("t2_maxlvl", 32'(maxlvl), 1);
    chk_rx("t2", 8, 16'b01011110);

    // Fill with ready low, one too many, then drain.
    bit_out_ready = 0; rx.delete();
    for (int i = 0; i < 6; i++) begin
      sample_in = 8'(t3v[i]); sample_in_valid = 1;
      @(negedge clk);
      chk("t3_level", 32'(fifo_level), 32'(t3l[i]));
      chk("t3_ovf", 32'(overflow), (i == 5) ? 1 : 0);
    end
    sample_in_valid = 0; bit_out_ready = 1;
    repeat (14) @(negedge clk);
    chk_rx("t3", 10, 16'b1000110110);
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // Reset while in the LSB half with two symbols queued.
    sample_in = 100; sample_in_valid = 1;
    repeat (3) @(negedge clk);
    sample_in_valid = 0;
    chk("t4_pre_level", 32'(fifo_level), 2);
    chk("t4_pre_lsb", {30'd0, bit_out_valid, bit_out}, 32'b10);
    rstn = 0;
    @(negedge clk);
    chk("t4_valid", 32'(bit_out_valid), 0);
    chk("t4_level", 32'(fifo_level), 0);
    chk("t4_ovf", 32'(overflow), 0);
    rstn = 1; rx.delete();
    sample_in = -10; sample_in_valid = 1;
    @(negedge clk); sample_in_valid = 0;
    repeat (5) @(negedge clk);
    chk_rx("t4", 2, 16'b01);

    // Ready toggling every cycle during a level-3 stream.
    rx.delete(); sample_in = 100;
    for (int i = 0; i < 48; i++) begin
      bit_out_ready = i[0];
      sample_in_valid = (i % 6 == 0);
      @(negedge clk);
    end
    sample_in_valid = 0; bit_out_ready = 1;
    repeat (8) @(negedge clk);
    chk("t5_count", 32'(rx.size()), 16);
    for (int i = 0; i < rx.size(); i++) chk("t5_bit", 32'(rx[i]), (i % 2 == 0) ? 1 : 0);

`ifdef PAM4_RX_LEVEL_HIST_EN
    rstn = 0; @(negedge clk); rstn = 1;
    chk("h_rst", 32'(hist_cnt2), 0);
    sample_in = 10; sample_in_valid = 1;
    repeat (5) @(negedge clk);
    chk("h_sat", 32'(hist_cnt2), 3);
    hist_clr = 1;
    @(negedge clk);
    hist_clr = 0; sample_in_valid = 0;
    chk("h_clr", 32'(hist_cnt2), 0);
    repeat (12) @(negedge clk);
`endif

    // Randomized traffic, including exact threshold values and rare resets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: sample_in = -64;
        1: sample_in = 0;
        2: sample_in = 64;
        3: sample_in = -65;
        default: sample_in = 8'($urandom_range(0, 255));
      endcase
      sample_in_valid = ($urandom_range(0, 99) < 45);
      bit_out_ready   = ($urandom_range(0, 99) < 70);
      rstn            = ($urandom_range(0, 299) != 0);
`ifdef PAM4_RX_LEVEL_HIST_EN
      hist_clr        = ($urandom_range(0, 49) == 0);
`endif
      @(negedge clk);
    end
    rstn = 1; sample_in_valid = 0; bit_out_ready = 1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
